// File: rtl/axi4_lite_master.sv
// axi4_lite_master
//   Single-outstanding AXI4-Lite master. A command accepted on the CMD_*
//   interface becomes one AXI4-Lite read or write; the captured BRESP/RRESP
//   (plus RDATA for reads) comes back on RSP_*, held until RSP_READY.
//   ERR_COUNT is a saturating count of responses whose RESP != OKAY.
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   CMD_*                 command in (CMD_READY high only while idle)
//   RSP_*                 response out, held until RSP_READY
//   ERR_COUNT             saturating error-response counter
//   M_AXI_AW/W/B/AR/R*    AXI4-Lite master channels
module axi4_lite_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic                     CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0]    CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]    CMD_WDATA,
    input  logic [STRB_WIDTH-1:0]    CMD_WSTRB,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic                     RSP_WRITE,
    output logic [1:0]               RSP_RESP,
    output logic [DATA_WIDTH-1:0]    RSP_RDATA,
    output logic [ERR_CNT_WIDTH-1:0] ERR_COUNT,
    output logic                     M_AXI_AWVALID,
    input  logic                     M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0]    M_AXI_AWADDR,
    output logic                     M_AXI_WVALID,
    input  logic                     M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0]    M_AXI_WDATA,
    output logic [STRB_WIDTH-1:0]    M_AXI_WSTRB,
    input  logic                     M_AXI_BVALID,
    output logic                     M_AXI_BREADY,
    input  logic [1:0]               M_AXI_BRESP,
    output logic                     M_AXI_ARVALID,
    input  logic                     M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0]    M_AXI_ARADDR,
    input  logic                     M_AXI_RVALID,
    output logic                     M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0]    M_AXI_RDATA,
    input  logic [1:0]               M_AXI_RRESP
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP
    } state_t;

    state_t                   r_state;
    logic                     r_aw_done, r_w_done;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [STRB_WIDTH-1:0]    r_wstrb;
    logic                     r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                     r_rsp_valid, r_rsp_write;
    logic [1:0]               r_rsp_resp;
    logic [DATA_WIDTH-1:0]    r_rsp_rdata;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    logic w_aw_hs, w_w_hs, w_aw_done, w_w_done, w_err_sat;

    assign w_aw_hs   = r_awvalid && M_AXI_AWREADY;
    assign w_w_hs    = r_wvalid && M_AXI_WREADY;
    // "done" includes a handshake happening this very cycle, so AW and W
    // completing together moves straight on to WR_RESP.
    assign w_aw_done = r_aw_done || w_aw_hs;
    assign w_w_done  = r_w_done || w_w_hs;
    assign w_err_sat = &r_err_cnt;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_resp  <= 2'b00;
            r_rsp_rdata <= '0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (CMD_VALID) begin
                        r_addr  <= CMD_ADDR;
                        r_wdata <= CMD_WDATA;
                        r_wstrb <= CMD_WSTRB;
                        if (CMD_WRITE) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    r_aw_done <= w_aw_done;
                    r_w_done  <= w_w_done;
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID && r_bready) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b1;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_rdata <= '0;
                        if ((M_AXI_BRESP != 2'b00) && !w_err_sat)
                            r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
                        r_state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (r_arvalid && M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID && r_rready) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b0;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_rdata <= M_AXI_RDATA;
                        if ((M_AXI_RRESP != 2'b00) && !w_err_sat)
                            r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
                        r_state     <= RSP;
                    end
                end
                RSP: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign CMD_READY     = (r_state == IDLE);
    assign RSP_VALID     = r_rsp_valid;
    assign RSP_WRITE     = r_rsp_write;
    assign RSP_RESP      = r_rsp_resp;
    assign RSP_RDATA     = r_rsp_rdata;
    assign ERR_COUNT     = r_err_cnt;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master
//   Directed bench for axi4_lite_master. Stimulus pushes the expected
//   response into a scoreboard queue at command acceptance; a monitor pops
//   and compares on every RSP handshake. A small slave model answers each
//   channel after a configurable number of cycles.
module tb_axi4_lite_master;

    typedef struct packed {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [7:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        ARESET;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR, CMD_WDATA;
    logic [3:0]  CMD_WSTRB;
    logic        RSP_VALID, RSP_READY, RSP_WRITE;
    logic [1:0]  RSP_RESP;
    logic [31:0] RSP_RDATA;
    logic [7:0]  ERR_COUNT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    axi4_lite_master dut (
        .ACLK(clk), .ARESET(ARESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
        .RSP_RESP(RSP_RESP), .RSP_RDATA(RSP_RDATA), .ERR_COUNT(ERR_COUNT),
        .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY), .M_AXI_AWADDR(AWADDR),
        .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_WDATA(WDATA),
        .M_AXI_WSTRB(WSTRB),
        .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_BRESP(BRESP),
        .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY), .M_AXI_ARADDR(ARADDR),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY), .M_AXI_RDATA(RDATA),
        .M_AXI_RRESP(RRESP)
    );

    always #5 clk = ~clk;

    int   errs = 0, checks = 0;
    exp_t sb[$];
    int   err_m = 0;

    // slave knobs
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
    logic [31:0] r_data = '0;

    // bus observation
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int          aw_hi = 0, w_hi = 0, rr_hi = 0;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: each READY/VALID rises the configured number of cycles
    // after the master's request appears; decisions made on the falling edge.
    initial begin
        int aw_c, w_c, b_c, ar_c, r_c;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        BRESP = 0; RRESP = 0; RDATA = 0;
        forever begin
            @(negedge clk);
            if (!AWVALID) begin AWREADY = 0; aw_c = 0; end
            else begin AWREADY = (aw_c == aw_dly); aw_c++; end
            if (!WVALID) begin WREADY = 0; w_c = 0; end
            else begin WREADY = (w_c == w_dly); w_c++; end
            if (!BREADY) begin BVALID = 0; b_c = 0; end
            else begin BVALID = (b_c == b_dly); b_c++; end
            if (!ARVALID) begin ARREADY = 0; ar_c = 0; end
            else begin ARREADY = (ar_c == ar_dly); ar_c++; end
            if (!RREADY) begin RVALID = 0; r_c = 0; end
            else begin RVALID = (r_c == r_dly); r_c++; end
            BRESP = b_resp; RRESP = r_resp; RDATA = r_data;
        end
    end

    // Monitor: counts AXI activity, checks hold-stability, pops scoreboard.
    initial begin
        logic        w_hold, r_hold;
        logic [31:0] h_wdata, h_rdata;
        logic [3:0]  h_wstrb;
        logic        h_write;
        logic [1:0]  h_resp;
        exp_t        e;
        w_hold = 0; r_hold = 0;
        forever begin
            @(posedge clk);
            if (!ARESET) begin
                if (AWVALID) aw_hi++;
                if (WVALID)  w_hi++;
                if (RREADY)  rr_hi++;
                if (AWVALID && AWREADY) begin aw_hs++; cap_awaddr = AWADDR; end
                if (WVALID && WREADY) begin w_hs++; cap_wdata = WDATA; cap_wstrb = WSTRB; end
                if (BVALID && BREADY) b_hs++;
                if (ARVALID && ARREADY) begin ar_hs++; cap_araddr = ARADDR; end
                if (RVALID && RREADY) r_hs++;
                if (w_hold && WVALID) begin
                    chk("wdata_stable", WDATA, h_wdata);
                    chk("wstrb_stable", WSTRB, h_wstrb);
                end
                w_hold = WVALID && !WREADY;
                h_wdata = WDATA; h_wstrb = WSTRB;
                if (r_hold) begin
                    chk("rsp_valid_held", RSP_VALID, 1'b1);
                    chk("rsp_fields_held", {RSP_WRITE, RSP_RESP, RSP_RDATA},
                        {h_write, h_resp, h_rdata});
                end
                r_hold = RSP_VALID && !RSP_READY;
                h_write = RSP_WRITE; h_resp = RSP_RESP; h_rdata = RSP_RDATA;
                if (RSP_VALID && RSP_READY) begin
                    if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("rsp_write", RSP_WRITE, e.wr);
                        chk("rsp_resp", RSP_RESP, e.resp);
                        chk("rsp_rdata", RSP_RDATA, e.rdata);
                        chk("err_count", ERR_COUNT, e.err);
                    end
                end
            end else begin
                w_hold = 0; r_hold = 0;
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] resp, input logic [31:0] rd);
        int n;
        exp_t e;
        @(negedge clk);
        CMD_VALID = 1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!CMD_READY && n < 200);
        if (!CMD_READY) chk("cmd_accept_timeout", 0, 1);
        else begin
            if (resp != 2'b00 && err_m < 255) err_m++;
            e.wr = wr; e.resp = resp; e.rdata = wr ? 32'h0 : rd; e.err = 8'(err_m);
            sb.push_back(e);
        end
        @(negedge clk);
        CMD_VALID = 0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            chk("rsp_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int a0, w0, b0, ar0, rr0, n;
        ARESET = 1; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_WDATA = 0;
        CMD_WSTRB = 0; RSP_READY = 1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", CMD_READY, 1);
        chk("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
        chk("rst_rsp", {RSP_VALID, RSP_WRITE, RSP_RESP, RSP_RDATA}, 0);
        chk("rst_err", ERR_COUNT, 0);
        chk("rst_bus", {AWADDR, WDATA, WSTRB}, 0);
        ARESET = 0;

        // single write, slave ready immediately
        a0 = aw_hi; w0 = w_hi; b0 = b_hs;
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0);
        wait_rsp();
        chk("t1_aw_cycles", aw_hi - a0, 1);
        chk("t1_w_cycles", w_hi - w0, 1);
        chk("t1_b_hs", b_hs - b0, 1);
        chk("t1_cap", {cap_awaddr, cap_wdata, cap_wstrb}, {32'h10, 32'hDEADBEEF, 4'hF});

        // WREADY 3 cycles after AWREADY; BVALID delayed too
        w_dly = 3; b_dly = 2;
        a0 = aw_hi; w0 = w_hi; b0 = b_hs;
        issue(1, 32'h24, 32'hCAFEF00D, 4'h5, 2'b00, 0);
        wait_rsp();
        chk("t2_aw_cycles", aw_hi - a0, 1);
        chk("t2_w_cycles", w_hi - w0, 4);
        chk("t2_b_hs", b_hs - b0, 1);
        chk("t2_cap", {cap_awaddr, cap_wdata, cap_wstrb}, {32'h24, 32'hCAFEF00D, 4'h5});
        w_dly = 0; b_dly = 0;

        // AW after W, both delayed
        aw_dly = 2; w_dly = 1; b_resp = 2'b11;
        issue(1, 32'h28, 32'h01020304, 4'h3, 2'b11, 0);
        wait_rsp();
        aw_dly = 0; w_dly = 0; b_resp = 2'b00;

        // read with RVALID delayed 2 cycles
        r_dly = 2; r_data = 32'hDEADBEEF; rr0 = rr_hi;
        issue(0, 32'h10, 0, 0, 2'b00, 32'hDEADBEEF);
        wait_rsp();
        chk("t3_rready_cycles", rr_hi - rr0, 3);
        chk("t3_araddr", cap_araddr, 32'h10);
        r_dly = 0;

        // response held 5 cycles while CMD_VALID pulses
        RSP_READY = 0;
        issue(1, 32'h20, 32'h55AA55AA, 4'hF, 2'b00, 0);
        n = 0;
        while (!RSP_VALID && n < 50) begin @(negedge clk); n++; end
        chk("t4_rsp_valid", RSP_VALID, 1);
        ar0 = ar_hs; a0 = aw_hi;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            CMD_VALID = (i % 2 == 0); CMD_WRITE = 0; CMD_ADDR = 32'h30;
            @(posedge clk);
            chk("t4_cmd_ready", CMD_READY, 0);
            chk("t4_no_axi", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
        end
        @(negedge clk);
        CMD_VALID = 0;
        chk("t4_no_ar", ar_hs - ar0, 0);
        chk("t4_no_aw", aw_hi - a0, 0);
        RSP_READY = 1;
        r_data = 32'h12345678;
        issue(0, 32'h30, 0, 0, 2'b00, 32'h12345678);
        wait_rsp();
        chk("t4_araddr", cap_araddr, 32'h30);

        // saturating error counter
        r_resp = 2'b10;
        for (int i = 0; i < 257; i++) begin
            r_data = 32'h1000 + i;
            issue(0, 32'h40, 0, 0, 2'b10, 32'h1000 + i);
            wait_rsp();
        end
        chk("sat_err_count", ERR_COUNT, 8'd255);
        r_resp = 2'b00;

        // reset while AWVALID high and before AWREADY
        aw_dly = 1000;
        issue(1, 32'h50, 32'h11111111, 4'hF, 2'b00, 0);
        n = 0;
        while (!AWVALID && n < 20) begin @(negedge clk); n++; end
        chk("t6_awvalid_up", AWVALID, 1);
        ARESET = 1;
        @(negedge clk);
        ARESET = 0;
        sb.delete(); err_m = 0;
        chk("t6_awvalid", AWVALID, 0);
        chk("t6_wvalid", WVALID, 0);
        chk("t6_cmd_ready", CMD_READY, 1);
        chk("t6_rsp_valid", RSP_VALID, 0);
        chk("t6_err", ERR_COUNT, 0);
        aw_dly = 0;
        repeat (5) @(negedge clk);
        chk("t6_no_rsp", RSP_VALID, 0);

        // normal traffic after reset
        r_data = 32'hA5A5A5A5;
        issue(0, 32'h60, 0, 0, 2'b00, 32'hA5A5A5A5);
        wait_rsp();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
